// File: rtl/alu_rf_pkg.sv
// Shared opcode, state and flag definitions for the ALU/register-file datapath.
package alu_rf_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ST_W = 2;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA   = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd8;
  localparam logic [OP_W-1:0] OP_INC   = 4'd9;
  localparam logic [OP_W-1:0] OP_DEC   = 4'd10;
  localparam logic [OP_W-1:0] OP_SLT   = 4'd11;
  localparam logic [OP_W-1:0] OP_SGT   = 4'd12;
  localparam logic [OP_W-1:0] OP_POP   = 4'd13;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd14;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd15;

  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_READ = 2'd1;
  localparam logic [ST_W-1:0] S_EXEC = 2'd2;
  localparam logic [ST_W-1:0] S_WB   = 2'd3;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_rf_datapath_rf.sv
// Register file: two combinational read ports, one synchronous write port, async clear.
module rf_multiport
  import alu_rf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [WIDTH-1:0]      rdata_a_c,
  output logic [WIDTH-1:0]      rdata_b_c
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  // Storage array: cleared on reset, written on we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports; the caller registers these in its READ state.
  always_comb begin
    rdata_a_c = regs[raddr_a];
    rdata_b_c = regs[raddr_b];
  end

endmodule

// File: rtl/alu_rf_datapath.sv
// Execute stage: request latch, READ/EXEC/WB sequencer, ALU and sticky status flags.
module alu_rf_datapath
  import alu_rf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            alu_op,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  wb_en,
  input  logic                  ext_sel,
  input  logic [WIDTH-1:0]      ext_data,
  output logic [WIDTH-1:0]      result,
  output logic                  result_valid,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_ovf,
  output logic                  busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  logic [ST_W-1:0]       state, state_nxt;
  logic                  accept_c;

  logic [OP_W-1:0]       op_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                  wb_en_q, ext_sel_q;
  logic [WIDTH-1:0]      ext_data_q;

  logic [WIDTH-1:0]      a_q, b_q;
  logic [WIDTH-1:0]      rf_a_c, rf_b_c;

  logic [WIDTH-1:0]      alu_res_c;
  logic                  alu_carry_c, alu_ovf_c;
  logic [WIDTH-1:0]      rhs_c;
  logic [WIDTH:0]        sum_c, diff_c;
  logic [CNT_W-1:0]      pop_c;

  assign accept_c = (state == S_IDLE) && op_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed READ -> EXEC -> WB walk after an accept.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (op_valid) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered handshake outputs, ready only while the next state is IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      op_ready <= (state_nxt == S_IDLE);
      busy     <= (state_nxt != S_IDLE);
    end
  end

  // Request latch, captured on the accept edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
      ext_sel_q  <= 1'b0;
      ext_data_q <= '0;
    end else if (accept_c) begin
      op_q       <= alu_op;
      rs1_q      <= rs1;
      rs2_q      <= rs2;
      rd_q       <= rd;
      wb_en_q    <= wb_en;
      ext_sel_q  <= ext_sel;
      ext_data_q <= ext_data;
    end
  end

  rf_multiport #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we        ((state == S_WB) && wb_en_q),
    .waddr     (rd_q),
    .wdata     (result),
    .raddr_a   (rs1_q),
    .raddr_b   (rs2_q),
    .rdata_a_c (rf_a_c),
    .rdata_b_c (rf_b_c)
  );

  // Operand registers, loaded in READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_READ) begin
      a_q <= rf_a_c;
      b_q <= rf_b_c;
    end
  end

  // Shared adder/subtractor: INC/DEC reuse it with a constant 1 operand.
  always_comb begin
    rhs_c  = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WIDTH'(1) : b_q;
    sum_c  = {1'b0, a_q} + {1'b0, rhs_c};
    diff_c = {1'b0, a_q} - {1'b0, rhs_c};
  end

  // Population count of operand A.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) pop_c = pop_c + CNT_W'(a_q[i]);
  end

  // ALU result and arithmetic flags; diff_c[WIDTH] is the unsigned borrow.
  always_comb begin
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    case (op_q)
      OP_ADD, OP_INC: begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
        alu_ovf_c   = (a_q[MSB] == rhs_c[MSB]) && (sum_c[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_DEC: begin
        alu_res_c   = diff_c[WIDTH-1:0];
        alu_carry_c = diff_c[WIDTH];
        alu_ovf_c   = (a_q[MSB] != rhs_c[MSB]) && (diff_c[MSB] != a_q[MSB]);
      end
      OP_AND:   alu_res_c = a_q & b_q;
      OP_OR:    alu_res_c = a_q | b_q;
      OP_XOR:   alu_res_c = a_q ^ b_q;
      OP_NOT:   alu_res_c = ~a_q;
      OP_SLL:   alu_res_c = a_q << b_q[SH_W-1:0];
      OP_SRA:   alu_res_c = WIDTH'($signed(a_q) >>> b_q[SH_W-1:0]);
      OP_SRL:   alu_res_c = a_q >> b_q[SH_W-1:0];
      OP_SLT:   alu_res_c = WIDTH'($signed(a_q) < $signed(b_q));
      OP_SGT:   alu_res_c = WIDTH'($signed(a_q) > $signed(b_q));
      OP_POP:   alu_res_c = WIDTH'(pop_c);
      OP_PASSA: alu_res_c = a_q;
      OP_PASSB: alu_res_c = b_q;
      default:  alu_res_c = '0;
    endcase
  end

  // Result, sticky flags and completion pulse; ext_sel bypasses the ALU and keeps flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
      flag_ovf     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == S_WB);
      if (state == S_EXEC) begin
        if (ext_sel_q) begin
          result <= ext_data_q;
        end else begin
          result     <= alu_res_c;
          flag_zero  <= (alu_res_c == '0);
          flag_carry <= alu_carry_c;
          flag_ovf   <= alu_ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rf_datapath.sv
// Scoreboard bench for alu_rf_datapath (WIDTH=32, NUM_REGS=16).
module tb_alu_rf_datapath;
  import alu_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  alu_op;
  logic [3:0]  rs1, rs2, rd;
  logic        wb_en, ext_sel;
  logic [31:0] ext_data;
  logic [31:0] result;
  logic        result_valid;
  logic        flag_zero, flag_carry, flag_ovf;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        z, c, o;
    time         t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_regs [16];
  logic        m_z, m_c, m_o;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  alu_rf_datapath #(.WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .wb_en(wb_en),
    .ext_sel(ext_sel), .ext_data(ext_data), .result(result),
    .result_valid(result_valid), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .flag_ovf(flag_ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model of one operation, independent 64-bit arithmetic.
  task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ext, input logic [31:0] data, output exp_t e);
    longint      sa, sbv, r;
    logic [63:0] u;
    logic [31:0] res, rhs;
    logic        c, o;
    int          sh;
    sh  = int'(b[4:0]);
    c   = 1'b0;
    o   = 1'b0;
    res = '0;
    rhs = (op == OP_INC || op == OP_DEC) ? 32'd1 : b;
    sa  = longint'($signed(a));
    sbv = longint'($signed(rhs));
    case (op)
      OP_ADD, OP_INC: begin
        u = {32'b0, a} + {32'b0, rhs}; res = u[31:0]; c = u[32];
        r = sa + sbv; o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      OP_SUB, OP_DEC: begin
        res = a - rhs; c = (a < rhs);
        r = sa - sbv; o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT:   res = ~a;
      OP_SLL:   res = a << sh;
      OP_SRA:   begin u = {{32{a[31]}}, a} >> sh; res = u[31:0]; end
      OP_SRL:   res = a >> sh;
      OP_SLT:   res = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      OP_SGT:   res = (longint'($signed(a)) > longint'($signed(b))) ? 32'd1 : 32'd0;
      OP_POP:   res = 32'($countones(a));
      OP_PASSA: res = a;
      default:  res = b;
    endcase
    if (ext) begin
      res = data;
    end else begin
      m_z = (res == 32'd0);
      m_c = c;
      m_o = o;
    end
    e.res = res; e.z = m_z; e.c = m_c; e.o = m_o; e.t = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_z = 1'b0; m_c = 1'b0; m_o = 1'b0;
  endtask

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!op_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("ready_timeout", 64'(op_ready), 64'd1);
  endtask

  task automatic issue(input logic [3:0] op, input int s1, input int s2, input int d,
                       input logic we, input logic ext, input logic [31:0] data);
    exp_t e;
    wait_ready();
    op_valid = 1'b1; alu_op = op; rs1 = 4'(s1); rs2 = 4'(s2); rd = 4'(d);
    wb_en = we; ext_sel = ext; ext_data = data;
    @(posedge clk);
    predict(op, m_regs[s1], m_regs[s2], ext, data, e);
    e.t = $time;
    sb.push_back(e);
    if (we) m_regs[d] = e.res;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic load(input int d, input logic [31:0] v);
    issue(OP_PASSA, 0, 0, d, 1'b1, 1'b1, v);
  endtask

  // Completion monitor: pops and compares one scoreboard entry per result_valid.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(result), 64'(mon_e.res));
        check("flag_zero", 64'(flag_zero), 64'(mon_e.z));
        check("flag_carry", 64'(flag_carry), 64'(mon_e.c));
        check("flag_ovf", 64'(flag_ovf), 64'(mon_e.o));
        check("latency", 64'($time - mon_e.t), 64'd35);
      end
    end
  end

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    int g;
    rst = 1'b1; op_valid = 1'b0; alu_op = '0; rs1 = '0; rs2 = '0; rd = '0;
    wb_en = 1'b0; ext_sel = 1'b0; ext_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(op_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({flag_zero, flag_carry, flag_ovf}), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);

    // Reset contents: PASSA r3 reads zero.
    issue(OP_PASSA, 3, 0, 0, 1'b0, 1'b0, 32'd0);

    // Overflowing ADD.
    load(1, 32'h7FFF_FFFF);
    load(2, 32'd1);
    issue(OP_ADD, 1, 2, 3, 1'b1, 1'b0, 32'd0);
    issue(OP_PASSA, 3, 0, 0, 1'b0, 1'b0, 32'd0);

    // Borrow on SUB and DEC wrap.
    load(1, 32'd0);
    load(2, 32'd1);
    issue(OP_SUB, 1, 2, 4, 1'b1, 1'b0, 32'd0);
    issue(OP_DEC, 1, 0, 5, 1'b1, 1'b0, 32'd0);

    // Shifts use only the low 5 bits of B; popcount.
    load(6, 32'h8000_00F0);
    load(7, 32'h0000_0024);
    issue(OP_SRA, 6, 7, 9, 1'b0, 1'b0, 32'd0);
    issue(OP_SRL, 6, 7, 9, 1'b0, 1'b0, 32'd0);
    issue(OP_SLL, 6, 7, 9, 1'b0, 1'b0, 32'd0);
    issue(OP_POP, 6, 0, 9, 1'b0, 1'b0, 32'd0);

    // op_valid held high: accepts every 4 edges, busy for 3 cycles after each.
    wait_ready();
    op_valid = 1'b1; alu_op = OP_PASSA; rs1 = 4'd6; rs2 = 4'd0; rd = 4'd0;
    wb_en = 1'b0; ext_sel = 1'b0; ext_data = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      if (k % 4 == 0) begin
        predict(OP_PASSA, m_regs[6], m_regs[0], 1'b0, 32'd0, e);
        e.t = $time;
        sb.push_back(e);
      end
      @(negedge clk);
      check("hs_busy", 64'(busy), (k % 4 != 3) ? 64'd1 : 64'd0);
      if (k == 11) op_valid = 1'b0;
    end

    // Same-register operands and wb_en=0.
    load(1, 32'd3);
    issue(OP_ADD, 1, 1, 1, 1'b1, 1'b0, 32'd0);
    issue(OP_PASSA, 1, 0, 0, 1'b0, 1'b0, 32'd0);
    issue(OP_ADD, 1, 1, 1, 1'b0, 1'b0, 32'd0);
    issue(OP_PASSA, 1, 0, 0, 1'b0, 1'b0, 32'd0);

    // Opcode sweep: random operands, then signed/unsigned extremes.
    for (int pass = 0; pass < 2; pass++) begin
      for (int op = 0; op < 16; op++) begin
        ra = (pass == 0) ? $urandom : 32'h8000_0000;
        rb = (pass == 0) ? $urandom : 32'hFFFF_FFFF;
        load(10, ra);
        load(11, rb);
        issue(4'(op), 10, 11, 12, 1'b1, 1'b0, 32'd0);
      end
    end

    // Reset while in EXEC: no completion, no write, back to IDLE.
    load(8, 32'd0);
    wait_ready();
    op_valid = 1'b1; alu_op = OP_ADD; rs1 = 4'd6; rs2 = 4'd7; rd = 4'd8;
    wb_en = 1'b1; ext_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(op_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("midrst_idle", 64'(op_ready), 64'd1);
    check("midrst_result", 64'(result), 64'd0);
    issue(OP_PASSA, 8, 0, 0, 1'b0, 1'b0, 32'd0);

    g = 0;
    while (sb.size() > 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rf_datapath.md
# alu_rf_datapath

Parametrised register-file plus ALU datapath that executes one operation per request through a four-state sequencer: operand read, execute, write-back. A valid/ready handshake issues requests, a one-cycle `result_valid` pulse reports completion, and sticky status flags record the last ALU operation. The block is the execute stage for the processor's control unit: the controller issues one operation and waits for `result_valid` before issuing the next.

## Interface
- `WIDTH`, 32: data width, ≥ 8, power of two.
- `NUM_REGS`, 16: register count, power of two, ≥ 2; `ADDR_WIDTH = $clog2(NUM_REGS)` (derived localparam).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op_valid` in 1: request present.
- `op_ready` out 1: block can accept a request; high only in IDLE.
- `alu_op` in 4: opcode (see Operation).
- `rs1`, `rs2` in ADDR_WIDTH: source register addresses (operands A, B).
- `rd` in ADDR_WIDTH: destination register address.
- `wb_en` in 1: write the result to `rd`.
- `ext_sel` in 1: the result is `ext_data` instead of the ALU output.
- `ext_data` in WIDTH: external write data.
- `result` out WIDTH: result of the last completed operation.
- `result_valid` out 1: one-cycle completion pulse.
- `flag_zero`, `flag_carry`, `flag_ovf` out 1: status of the last ALU operation.
- `busy` out 1: equal to `~op_ready`.

## Operation
- **FSM states:** IDLE → READ → EXEC → WB → IDLE.
- **Accept:** a request is accepted when the FSM is in IDLE and `op_valid` is high.
  - All request fields are latched on the accept edge.
  - Request fields are ignored in every other state.
- **READ:** latch A = reg[rs1] and B = reg[rs2].
- **EXEC:** compute and register the result and the flags.
- **WB:**
  - If `wb_en` is high, write the result to reg[rd].
  - Pulse `result_valid`.
  - Return to IDLE.
- **Opcodes:**

  | Code | Mnemonic | Result |
  |---|---|---|
  | 0 | ADD | A+B |
  | 1 | SUB | A−B |
  | 2 | AND | A&B |
  | 3 | OR | A\|B |
  | 4 | XOR | A^B |
  | 5 | NOT | ~A |
  | 6 | SLL | A<<B[s] |
  | 7 | SRA | arithmetic A>>B[s] |
  | 8 | SRL | logical A>>B[s] |
  | 9 | INC | A+1 |
  | 10 | DEC | A−1 |
  | 11 | SLT | signed A<B ? 1 : 0 |
  | 12 | SGT | signed A>B ? 1 : 0 |
  | 13 | POP | popcount(A) |
  | 14 | PASSA | A |
  | 15 | PASSB | B |

  - s = `$clog2(WIDTH)` low bits of B; the upper bits of B are ignored.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH.
- **flag_carry:**
  - ADD and INC: carry-out of bit WIDTH−1.
  - SUB and DEC: borrow, i.e. unsigned A < subtrahend.
  - All other opcodes: 0.
- **flag_ovf:** signed overflow for ADD, SUB, INC and DEC; 0 for all other opcodes.
- **flag_zero:** result == 0, for every opcode.
- **ext_sel = 1:**
  - The result equals the `ext_data` value latched at accept.
  - The ALU is bypassed.
  - All three flags hold their previous values.
- **Hold rules:**
  - `result` holds its value until the next EXEC.
  - The flags hold their values until the next EXEC of a non-`ext_sel` operation.
- **Hazards:** none. Operations are serialised, so a write in WB is visible to the READ of the next operation.
- **Same-register operands:** `rd` may equal `rs1` or `rs2`; the operands are already latched before the write.

## Timing
- **Reset (asynchronous, any state):**
  - FSM goes to IDLE and all registers clear to 0.
  - `result` = 0, all flags = 0, `result_valid` = 0.
  - `op_ready` = 1 (`busy` = 0).
  - An operation in flight is discarded with no write.
- **Latency:** accept on edge t; `result` and the flags update on edge t+2; `result_valid` is high in the cycle after edge t+3.
  - The write to reg[rd] lands on edge t+3.
- **Throughput:** one operation per 4 cycles.
  - `op_ready` rises in the cycle after WB, so back-to-back accepts are 4 edges apart.
- **Register file:** reads are synchronous (registered in READ); writes are synchronous in WB only.
- **`op_valid` while busy:** no effect. The requester holds its request until it sees `op_ready`.

## Structure
- **Package `alu_rf_pkg`:**
  - opcode localparams OP_ADD … OP_PASSB (4 bits);
  - FSM state encoding S_IDLE, S_READ, S_EXEC, S_WB (2 bits).
- **Sub-module `rf_multiport`:**
  - parameters WIDTH and NUM_REGS;
  - two read ports, one write port, asynchronous clear on `rst`.
- **Top level:** FSM, operand and request latches, the combinational ALU (a function or always block) and the flag registers.

## Test plan
- **Reset:** after `rst`, all registers read 0, `op_ready` = 1 and all flags are 0 → PASSA r3 gives `result` = 0 and `flag_zero` = 1.
- **External load and ADD:**
  - Load r1 = 0x7FFF_FFFF and r2 = 1 via `ext_sel`.
  - ADD r3 = r1 + r2 gives 0x8000_0000 with `flag_ovf` = 1 and `flag_carry` = 0.
  - `result_valid` appears exactly 3 cycles after accept.
- **SUB borrow and DEC wrap:**
  - r1 = 0 and r2 = 1; SUB gives 0xFFFF_FFFF with `flag_carry` = 1.
  - DEC r1 gives 0xFFFF_FFFF with `flag_carry` = 1.
- **Shifts and popcount:**
  - A = 0x8000_00F0, B = 0x24 (shift amount 4).
  - SRA gives 0xF800_000F, SRL gives 0x0800_000F, SLL gives 0x0000_0F00.
  - POP A gives 5.
- **Handshake and same-register operation:**
  - Holding `op_valid` high continuously gives accepts every 4 cycles, and `busy` is high in the three cycles after each accept edge.
  - ADD r1 = r1 + r1 with r1 = 3 gives r1 = 6.
  - `wb_en` = 0 leaves r1 unchanged.
- **Reset mid-operation:** asserting `rst` during EXEC gives no `result_valid`, leaves `rd` unwritten (0) and returns the block to IDLE with `op_ready` = 1.
